// File: rtl/fpu_pkg.sv
// Shared FPU constants: default field widths, aligned-mantissa layout and
// the shift-amount width used by the alignment and normalise shifters.
package fpu_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int FRAC_W_DEF = 23;

  // Aligned mantissa is {carry, hidden, fraction, guard, round, sticky}
  localparam int GRS_W      = 3;
  localparam int GUARD_BIT  = 2;
  localparam int ROUND_BIT  = 1;
  localparam int STICKY_BIT = 0;

  localparam int M_W_DEF  = FRAC_W_DEF + 5;
  localparam int SH_W_DEF = $clog2(M_W_DEF) + 1;

  function automatic int m_width(input int frac_w);
    return frac_w + 5;
  endfunction

  function automatic int sh_width(input int m_w);
    return $clog2(m_w) + 1;
  endfunction

endpackage

// File: rtl/fp_sticky_shr.sv
// Logical right shifter that ORs every bit shifted out into the result LSB
// and collapses to a lone sticky bit once the shift covers the whole word.
module fp_sticky_shr #(
  parameter int W    = 28,
  parameter int SH_W = $clog2(W) + 1
) (
  input  logic [W-1:0]    in_i,
  input  logic [SH_W-1:0] sh_i,
  output logic [W-1:0]    out_o
);

  logic [W-1:0] shifted_s;
  logic [W-1:0] lost_mask_s;
  logic         lost_s;

  // Shift, gather the discarded bits and fold them into the LSB
  always_comb begin
    shifted_s   = in_i >> sh_i;
    lost_mask_s = ~({W{1'b1}} << sh_i);
    lost_s      = |(in_i & lost_mask_s);
    if (sh_i >= SH_W'(W)) begin
      out_o = {{(W-1){1'b0}}, |in_i};
    end else begin
      out_o = {shifted_s[W-1:1], shifted_s[0] | lost_s};
    end
  end

endmodule

// File: rtl/fp_align_pipe.sv
// Two-stage FP adder operand alignment: stage 1 unpacks, compares and swaps,
// stage 2 right-shifts the smaller mantissa with sticky. Valid/ready pipeline.
module fp_align_pipe
  import fpu_pkg::*;
#(
  parameter int  EXP_W  = EXP_W_DEF,
  parameter int  FRAC_W = FRAC_W_DEF,
  localparam int M_W    = m_width(FRAC_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              a_sign,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic [FRAC_W-1:0] b_frac,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              s_a,
  output logic              s_b,
  output logic [EXP_W-1:0]  e_o,
  output logic [M_W-1:0]    m_a,
  output logic [M_W-1:0]    m_b,
  output logic              comp,
  output logic              eq,
  output logic              eff_sub
);

  localparam int SH_W  = sh_width(M_W);
  localparam int CMP_W = (EXP_W > SH_W) ? EXP_W : SH_W;

  logic adv1_s, adv2_s;

  logic             a_hid_s, b_hid_s, b_sign_eff_s, swap_s, same_s;
  logic [EXP_W-1:0] a_eexp_s, b_eexp_s;
  logic [M_W-1:0]   a_mant_s, b_mant_s;

  logic             s1_sa_d, s1_sb_d;
  logic [EXP_W-1:0] s1_e_d, s1_diff_d;
  logic [M_W-1:0]   s1_ma_d, s1_mb_d;

  logic             s1_valid_q, s1_sa_q, s1_sb_q, s1_comp_q, s1_eq_q;
  logic [EXP_W-1:0] s1_e_q, s1_diff_q;
  logic [M_W-1:0]   s1_ma_q, s1_mb_q;

  logic [SH_W-1:0]  sh_amt_s;
  logic [M_W-1:0]   mb_shift_s;

  logic             s2_valid_q, s2_sa_q, s2_sb_q, s2_comp_q, s2_eq_q, s2_eff_sub_q;
  logic [EXP_W-1:0] s2_e_q;
  logic [M_W-1:0]   s2_ma_q, s2_mb_q;

  assign adv2_s   = ~s2_valid_q | out_ready;
  assign adv1_s   = ~s1_valid_q | adv2_s;
  assign in_ready = adv1_s;

  // Denormals use effective exponent 1 with a clear hidden bit
  assign a_hid_s      = (a_exp != {EXP_W{1'b0}});
  assign b_hid_s      = (b_exp != {EXP_W{1'b0}});
  assign a_eexp_s     = a_hid_s ? a_exp : {{(EXP_W-1){1'b0}}, 1'b1};
  assign b_eexp_s     = b_hid_s ? b_exp : {{(EXP_W-1){1'b0}}, 1'b1};
  assign a_mant_s     = {1'b0, a_hid_s, a_frac, {GRS_W{1'b0}}};
  assign b_mant_s     = {1'b0, b_hid_s, b_frac, {GRS_W{1'b0}}};
  assign b_sign_eff_s = b_sign ^ sub;
  assign swap_s       = {b_eexp_s, b_frac} > {a_eexp_s, a_frac};
  assign same_s       = {b_eexp_s, b_frac} == {a_eexp_s, a_frac};

  // Order operands so the larger magnitude is first
  always_comb begin
    s1_ma_d   = a_mant_s;
    s1_mb_d   = b_mant_s;
    s1_e_d    = a_eexp_s;
    s1_diff_d = a_eexp_s - b_eexp_s;
    s1_sa_d   = a_sign;
    s1_sb_d   = b_sign_eff_s;
    if (swap_s) begin
      s1_ma_d   = b_mant_s;
      s1_mb_d   = a_mant_s;
      s1_e_d    = b_eexp_s;
      s1_diff_d = b_eexp_s - a_eexp_s;
      s1_sa_d   = b_sign_eff_s;
      s1_sb_d   = a_sign;
    end else begin
      s1_ma_d   = a_mant_s;
    end
  end

  // Stage 1 register: valid follows the handshake, data loads on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ma_q    <= {M_W{1'b0}};
      s1_mb_q    <= {M_W{1'b0}};
      s1_e_q     <= {EXP_W{1'b0}};
      s1_diff_q  <= {EXP_W{1'b0}};
      s1_sa_q    <= 1'b0;
      s1_sb_q    <= 1'b0;
      s1_comp_q  <= 1'b0;
      s1_eq_q    <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
      end else if (adv1_s) begin
        s1_valid_q <= in_valid;
      end
      if (adv1_s && in_valid) begin
        s1_ma_q   <= s1_ma_d;
        s1_mb_q   <= s1_mb_d;
        s1_e_q    <= s1_e_d;
        s1_diff_q <= s1_diff_d;
        s1_sa_q   <= s1_sa_d;
        s1_sb_q   <= s1_sb_d;
        s1_comp_q <= swap_s;
        s1_eq_q   <= same_s;
      end
    end
  end

  // Clamp the exponent difference into the shifter's amount range
  always_comb begin
    if (CMP_W'(s1_diff_q) >= CMP_W'(M_W)) begin
      sh_amt_s = SH_W'(M_W);
    end else begin
      sh_amt_s = SH_W'(s1_diff_q);
    end
  end

  fp_sticky_shr #(
    .W    (M_W),
    .SH_W (SH_W)
  ) u_shr (
    .in_i  (s1_mb_q),
    .sh_i  (sh_amt_s),
    .out_o (mb_shift_s)
  );

  // Stage 2 register drives every output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_ma_q      <= {M_W{1'b0}};
      s2_mb_q      <= {M_W{1'b0}};
      s2_e_q       <= {EXP_W{1'b0}};
      s2_sa_q      <= 1'b0;
      s2_sb_q      <= 1'b0;
      s2_comp_q    <= 1'b0;
      s2_eq_q      <= 1'b0;
      s2_eff_sub_q <= 1'b0;
    end else begin
      if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (adv2_s) begin
        s2_valid_q <= s1_valid_q;
      end
      if (adv2_s && s1_valid_q) begin
        s2_ma_q      <= s1_ma_q;
        s2_mb_q      <= mb_shift_s;
        s2_e_q       <= s1_e_q;
        s2_sa_q      <= s1_sa_q;
        s2_sb_q      <= s1_sb_q;
        s2_comp_q    <= s1_comp_q;
        s2_eq_q      <= s1_eq_q;
        s2_eff_sub_q <= s1_sa_q ^ s1_sb_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign m_a       = s2_ma_q;
  assign m_b       = s2_mb_q;
  assign e_o       = s2_e_q;
  assign s_a       = s2_sa_q;
  assign s_b       = s2_sb_q;
  assign comp      = s2_comp_q;
  assign eq        = s2_eq_q;
  assign eff_sub   = s2_eff_sub_q;

endmodule

// File: tb/tb_fp_align_pipe.sv
// Directed bench for fp_align_pipe (EXP_W=8, FRAC_W=23): alignment vectors,
// back-pressure, flush and mid-stream reset with hand-computed expectations.
module tb_fp_align_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        a_sign, b_sign, sub, s_a, s_b, comp, eq, eff_sub;
  logic [7:0]  a_exp, b_exp, e_o;
  logic [22:0] a_frac, b_frac;
  logic [27:0] m_a, m_b;

  int checks = 0;
  int errors = 0;

  fp_align_pipe #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_frac(a_frac), .b_frac(b_frac), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s_a(s_a), .s_b(s_b), .e_o(e_o), .m_a(m_a), .m_b(m_b),
    .comp(comp), .eq(eq), .eff_sub(eff_sub)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic as, input logic [7:0] ae, input logic [22:0] af,
                        input logic bs, input logic [7:0] be, input logic [22:0] bf,
                        input logic sb);
    a_sign = as; a_exp = ae; a_frac = af;
    b_sign = bs; b_exp = be; b_frac = bf; sub = sb;
  endtask

  task automatic check_out(input string tag, input logic [27:0] ema, input logic [27:0] emb,
                           input logic [7:0] ee, input logic esa, input logic esb,
                           input logic ecomp, input logic eeq);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_m_a"}, 32'(m_a), 32'(ema));
    check({tag, "_m_b"}, 32'(m_b), 32'(emb));
    check({tag, "_e_o"}, 32'(e_o), 32'(ee));
    check({tag, "_s_a"}, 32'(s_a), 32'(esa));
    check({tag, "_s_b"}, 32'(s_b), 32'(esb));
    check({tag, "_comp"}, 32'(comp), 32'(ecomp));
    check({tag, "_eq"}, 32'(eq), 32'(eeq));
    check({tag, "_eff_sub"}, 32'(eff_sub), 32'(esa ^ esb));
  endtask

  // One isolated transaction: checks 2-cycle latency, then the result
  task automatic run_vec(input string tag,
                         input logic as, input logic [7:0] ae, input logic [22:0] af,
                         input logic bs, input logic [7:0] be, input logic [22:0] bf,
                         input logic sb,
                         input logic [27:0] ema, input logic [27:0] emb, input logic [7:0] ee,
                         input logic esa, input logic esb, input logic ecomp, input logic eeq);
    @(negedge clk);
    set_in(as, ae, af, bs, be, bf, sb);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out(tag, ema, emb, ee, esa, esb, ecomp, eeq);
  endtask

  logic [27:0] bp_mb [4];
  int acc, emi;

  initial begin
    bp_mb = '{28'h2000000, 28'h1000000, 28'h0800000, 28'h0400000};
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in(1'b0, 8'd0, 23'd0, 1'b0, 8'd0, 23'd0, 1'b0);

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_m_a", 32'(m_a), 32'd0);
    check("rst_e_o", 32'(e_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Alignment vectors
    run_vec("one_plus_half", 1'b0, 8'd127, 23'd0, 1'b0, 8'd126, 23'd0, 1'b0,
            28'h4000000, 28'h2000000, 8'd127, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("swap_neg", 1'b0, 8'd126, 23'd0, 1'b1, 8'd127, 23'd0, 1'b0,
            28'h4000000, 28'h2000000, 8'd127, 1'b1, 1'b0, 1'b1, 1'b0);
    run_vec("sticky4", 1'b0, 8'd131, 23'd0, 1'b0, 8'd127, 23'd1, 1'b0,
            28'h4000000, 28'h0400001, 8'd131, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sat100", 1'b0, 8'd200, 23'd0, 1'b0, 8'd100, 23'd1, 1'b0,
            28'h4000000, 28'h0000001, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("equal_sub", 1'b0, 8'd128, 23'h400000, 1'b0, 8'd128, 23'h400000, 1'b1,
            28'h6000000, 28'h6000000, 8'd128, 1'b0, 1'b1, 1'b0, 1'b1);
    run_vec("shift3_full", 1'b0, 8'd130, 23'd0, 1'b0, 8'd127, 23'h7FFFFF, 1'b0,
            28'h4000000, 28'h0FFFFFF, 8'd130, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("shift5_sticky", 1'b0, 8'd132, 23'd0, 1'b0, 8'd127, 23'd3, 1'b0,
            28'h4000000, 28'h0200001, 8'd132, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("shift27", 1'b0, 8'd154, 23'd0, 1'b0, 8'd127, 23'd0, 1'b0,
            28'h4000000, 28'h0000001, 8'd154, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sat_zero", 1'b0, 8'd200, 23'd0, 1'b0, 8'd0, 23'd0, 1'b0,
            28'h4000000, 28'h0000000, 8'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec("sub_swap", 1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0, 1'b1,
            28'h4000000, 28'h2000000, 8'd128, 1'b1, 1'b0, 1'b1, 1'b0);

    // Back-pressure: out_ready low for the first 3 cycles of a 4-pair stream
    acc = 0; emi = 0;
    for (int cyc = 0; cyc < 20 && emi < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      if (acc < 4) begin
        set_in(1'b0, 8'd127, 23'd0, 1'b0, 8'(126 - acc), 23'd0, 1'b0);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 1) check("bp_in_ready_hi", 32'(in_ready), 32'd1);
      if (cyc == 2) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_stall_valid", 32'(out_valid), 32'd1);
        check("bp_stall_m_b", 32'(m_b), 32'(bp_mb[0]));
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_out%0d_m_b", emi), 32'(m_b), 32'(bp_mb[emi]));
        check($sformatf("bp_out%0d_e_o", emi), 32'(e_o), 32'd127);
        emi++;
      end
      if (in_valid && in_ready) acc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_emitted", 32'(emi), 32'd4);
    @(negedge clk);
    check("bp_no_dup", 32'(out_valid), 32'd0);

    // Flush with two entries in flight; the input offered during flush is dropped
    @(negedge clk);
    set_in(1'b0, 8'd127, 23'd0, 1'b0, 8'd126, 23'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    set_in(1'b0, 8'd127, 23'd0, 1'b0, 8'd125, 23'd0, 1'b0);
    @(negedge clk);
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    set_in(1'b0, 8'd127, 23'd0, 1'b0, 8'd124, 23'd0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid0", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("fl_dropped", 32'(out_valid), 32'd0);
    set_in(1'b1, 8'd130, 23'd0, 1'b0, 8'd127, 23'd3, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("fl_new_lat", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_out("fl_new", 28'h4000000, 28'h0800003, 8'd130, 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream
    @(negedge clk);
    set_in(1'b0, 8'd127, 23'd0, 1'b0, 8'd126, 23'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_m_a", 32'(m_a), 32'd0);
    check("mr_m_b", 32'(m_b), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("mr_no_partial", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("mr_no_partial2", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_align_pipe.md
Name: fp_align_pipe

Overview:
- Parametrised, pipelined operand-alignment stage for the FPU adder/subtractor. Sits between operand unpack and the mantissa add/normalise stage.
- Takes two unpacked floating-point operands plus an add/sub mode. Compares magnitudes and swaps so the larger operand is first. Right-shifts the smaller mantissa by the exponent difference, folding lost bits into a sticky LSB.
- Two register stages with a valid/ready handshake, stall and flush; any exponent/fraction width.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width (hidden bit excluded).
- M_W, FRAC_W+5, aligned mantissa width, MSB to LSB: {carry, hidden, fraction, guard, round, sticky}. Derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous; kills all in-flight entries.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage 1 can accept this cycle.
- a_sign, b_sign  in  1 each  operand signs.
- a_exp, b_exp  in  EXP_W each  biased exponents.
- a_frac, b_frac  in  FRAC_W each  stored fractions.
- sub  in  1  1 = A-B, 0 = A+B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts.
- s_a, s_b  out  1 each  sign of larger operand; sign of smaller operand after sub applied.
- e_o  out  EXP_W  larger effective exponent.
- m_a  out  M_W  larger mantissa, unshifted.
- m_b  out  M_W  smaller mantissa, shifted, sticky in LSB.
- comp  out  1  1 when operands were swapped (|B|>|A|).
- eq  out  1  |A|==|B| (exponent and fraction equal).
- eff_sub  out  1  s_a XOR s_b.

Behaviour:
- Reset: every output register is 0, both stage valids are 0, so out_valid=0. in_ready=1 after reset. Reset mid-operation discards all entries; no partial output.
- Unpack (stage 1, combinational):
  - hidden = (exp!=0).
  - Effective exp = (exp==0) ? 1 : exp; denormals are treated as exponent 1.
  - Mantissa = {1'b0, hidden, frac, 3'b000}.
  - b_sign_eff = b_sign ^ sub.
- Compare (stage 1): swap when {eff_exp_b, frac_b} > {eff_exp_a, frac_a}, unsigned. Ties do not swap (comp=0, eq=1).
- Stage 1 register holds: larger mantissa, smaller mantissa, e_o, diff = e_max - e_min (EXP_W bits, non-negative), signs, comp, eq.
- Shift (stage 2):
  - If diff >= M_W: m_b = {(M_W-1){0}, |mant_small}.
  - Otherwise: m_b = mant_small >> diff, with m_b[0] = OR of (mant_small >> diff)[0] and all bits shifted out.
  - diff = 0 passes the mantissa unchanged.
- Registered outputs: m_a, e_o, s_a, s_b, comp, eq and eff_sub pass through stage 2 registers alongside m_b.
- Latency: 2 cycles from an accepted input to out_valid with no stalls. Throughput: 1 per cycle.
- Handshake:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1.
  - A transfer occurs on in_valid & in_ready, and on out_valid & out_ready.
  - While out_valid & ~out_ready, all outputs are held stable.
  - in_ready depends only on internal state and out_ready, never on in_valid.
- Simultaneous events:
  - When full, accept and emit in the same cycle without a bubble.
  - flush has priority over in_valid: s1_valid, s2_valid <= 0 next cycle and the input that cycle is dropped.
  - Data registers need not clear on flush.
- No exception handling: NaN/Inf are aligned as ordinary values and classified upstream.

Decomposition:
- Shared package fpu_pkg: EXP_W/FRAC_W defaults, M_W derivation, GRS bit-index constants.
- Add a shift-amount width constant of $clog2(M_W)+1.
- Sub-module: fp_sticky_shr (parametrised right shifter with sticky and saturation). Instantiated in stage 2 and reusable by the normaliser.

Test Plan:
- A=1.0 (exp 127, frac 0), B=0.5 (exp 126), sub=0 -> after 2 cycles:
  - m_a=0x4000000, m_b=0x2000000, e_o=127.
  - comp=0, eq=0, eff_sub=0.
- A=0.5, B=-1.0, sub=0 -> comp=1, m_a=0x4000000, m_b=0x2000000, s_a=1, s_b=0, eff_sub=1.
- Sticky and saturation:
  - A exp 131 frac 0, B exp 127 frac 1 -> m_b=0x0400001 (bit shifted out sets sticky).
  - A exp 200, B exp 100 frac 1 -> diff >= 28, m_b=0x0000001.
- A==B=3.0, sub=1 -> eq=1, comp=0, m_b==m_a, eff_sub=1.
- Back-pressure: stream 4 pairs with out_ready=0 for 3 cycles -> in_ready falls after 2 accepts, outputs held stable, all 4 results emitted in order and none lost or duplicated.
- Control:
  - flush with 2 entries in flight -> out_valid=0 next cycle; a new input 2 cycles later emerges normally.
  - rst asserted mid-stream -> out_valid=0 immediately and in_ready=1 after deassertion.
